// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU among NREQ requesters.
// One operation in flight: IDLE grants and registers operands, ISSUE captures, RESP returns.
module alu_share_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  input  logic [4*NREQ-1:0]    req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_branch,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [31:0]          alu_in1,
  output logic [31:0]          alu_in2,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_out,
  input  logic                 alu_branch
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rrPtr_q;
  logic [IDW-1:0]   owner_q;
  logic [31:0]      aluIn1_q, aluIn2_q;
  logic [3:0]       aluOp_q;
  logic [31:0]      rspData_q;
  logic             rspBranch_q;
  logic [IDW-1:0]   rspId_q;

  logic             grantFound;
  logic [IDW-1:0]   grantIdx;
  logic [IDW-1:0]   nextPtr;
  logic [31:0]      grantIn1, grantIn2;
  logic [3:0]       grantOp;
  logic             ownerAck;
  logic             loadOp;
  logic             captureRsp;

  // First asserted request at or after rrPtr_q, wrapping modulo NREQ.
  always_comb begin : grantSearch
    int unsigned idx;
    idx        = 0;
    grantFound = 1'b0;
    grantIdx   = '0;
    nextPtr    = '0;
    grantIn1   = '0;
    grantIn2   = '0;
    grantOp    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rrPtr_q) + k) % NREQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = IDW'(idx);
        nextPtr    = IDW'((idx + 1) % NREQ);
        grantIn1   = req_in1[32*idx +: 32];
        grantIn2   = req_in2[32*idx +: 32];
        grantOp    = req_op[4*idx +: 4];
      end
    end
  end

  always_comb begin
    ownerAck = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) ownerAck = rsp_ready[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    loadOp     = 1'b0;
    captureRsp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grantFound) begin
          loadOp  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        captureRsp = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (ownerAck) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == StIdle) && grantFound && (grantIdx == IDW'(i));
      rsp_valid[i] = (state_q == StResp) && (owner_q == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rrPtr_q     <= '0;
      owner_q     <= '0;
      aluIn1_q    <= '0;
      aluIn2_q    <= '0;
      aluOp_q     <= '0;
      rspData_q   <= '0;
      rspBranch_q <= 1'b0;
      rspId_q     <= '0;
    end else begin
      state_q <= state_d;
      // ALU operands only move on a grant, so the ALU sees no activity otherwise.
      if (loadOp) begin
        rrPtr_q  <= nextPtr;
        owner_q  <= grantIdx;
        aluIn1_q <= grantIn1;
        aluIn2_q <= grantIn2;
        aluOp_q  <= grantOp;
      end
      if (captureRsp) begin
        rspData_q   <= alu_out;
        rspBranch_q <= alu_branch;
        rspId_q     <= owner_q;
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign alu_in1    = aluIn1_q;
  assign alu_in2    = aluIn2_q;
  assign alu_op     = aluOp_q;
  assign rsp_data   = rspData_q;
  assign rsp_branch = rspBranch_q;
  assign rsp_id     = rspId_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant order, two-cycle latency, response hold).
module tb_alu_share_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpBeq  = 4'd6;
  localparam logic [3:0] OpBlt  = 4'd7;
  localparam logic [3:0] OpBltu = 4'd8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_in1;
  logic [32*NREQ-1:0]  req_in2;
  logic [4*NREQ-1:0]   req_op;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_data;
  logic                rsp_branch;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
  logic [31:0]         alu_in1, alu_in2;
  logic [3:0]          alu_op;
  logic [31:0]         alu_out;
  logic                alu_branch;

  always #5 clk = ~clk;

  function automatic logic [32:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      OpAdd:   return {1'b0, a + b};
      OpSub:   return {1'b0, a - b};
      OpAnd:   return {1'b0, a & b};
      OpOr:    return {1'b0, a | b};
      OpXor:   return {1'b0, a ^ b};
      OpSll:   return {1'b0, a << b[4:0]};
      OpBeq:   return {a == b, 32'h0};
      OpBlt:   return {$signed(a) < $signed(b), 32'h0};
      OpBltu:  return {a < b, 32'h0};
      default: return 33'h0;
    endcase
  endfunction

  assign {alu_branch, alu_out} = aluRef(alu_in1, alu_in2, alu_op);

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_branch (rsp_branch),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_branch (alu_branch)
  );

  int nCmp = 0;
  int nFail = 0;

  // Model: phase 0 idle, 1 operand issue, 2 response pending.
  int            mPhase;
  int            mPtr;
  int            mOwner;
  logic [31:0]   mIn1, mIn2, mData;
  logic [3:0]    mOp;
  logic          mBr;
  logic [NREQ-1:0] lastReady;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mPtr   = 0;
    mOwner = 0;
  endtask

  task automatic randomizeOperands();
    for (int i = 0; i < NREQ; i++) begin
      req_in1[32*i +: 32] = $urandom;
      req_in2[32*i +: 32] = $urandom;
      req_op[4*i +: 4]    = 4'($urandom_range(0, 8));
    end
  endtask

  // Check all outputs against the model for the current cycle, then advance one clock.
  task automatic step();
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] expRsp;
    int g;
    #1;
    expReady = '0;
    expRsp   = '0;
    g        = -1;
    if (mPhase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mPtr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) expReady[g] = 1'b1;
    if (mPhase == 2) expRsp[mOwner] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(expReady));
    chk("busy", 32'(busy), 32'(mPhase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(expRsp));
    if (mPhase == 1) begin
      chk("alu_in1", alu_in1, mIn1);
      chk("alu_in2", alu_in2, mIn2);
      chk("alu_op", 32'(alu_op), 32'(mOp));
    end
    if (mPhase == 2) begin
      chk("rsp_data", rsp_data, mData);
      chk("rsp_branch", 32'(rsp_branch), 32'(mBr));
      chk("rsp_id", 32'(rsp_id), 32'(mOwner));
    end
    lastReady = req_ready;
    if (mPhase == 0 && g >= 0) begin
      mOwner = g;
      mIn1   = req_in1[32*g +: 32];
      mIn2   = req_in2[32*g +: 32];
      mOp    = req_op[4*g +: 4];
      {mBr, mData} = aluRef(mIn1, mIn2, mOp);
      mPtr   = (g + 1) % NREQ;
      mPhase = 1;
    end else if (mPhase == 1) begin
      mPhase = 2;
    end else if (mPhase == 2 && rsp_ready[mOwner]) begin
      mPhase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    // Accepted operands must no longer matter.
    if (g >= 0) begin
      req_in1[32*g +: 32] = $urandom;
      req_in2[32*g +: 32] = $urandom;
      req_op[4*g +: 4]    = 4'($urandom_range(0, 8));
    end
  endtask

  task automatic runOne(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] expData, input logic expBr);
    logic [NREQ-1:0] oneHot;
    oneHot = '0;
    oneHot[r] = 1'b1;
    req_valid = oneHot;
    req_in1[32*r +: 32] = a;
    req_in2[32*r +: 32] = b;
    req_op[4*r +: 4]    = op;
    rsp_ready = '0;
    #1;
    chk("one_req_ready", 32'(req_ready), 32'(oneHot));
    step();
    req_valid = '0;
    req_in1[32*r +: 32] = 32'hDEAD_BEEF;
    step();
    #1;
    chk("one_rsp_valid", 32'(rsp_valid), 32'(oneHot));
    chk("one_rsp_data", rsp_data, expData);
    chk("one_rsp_branch", 32'(rsp_branch), 32'(expBr));
    chk("one_rsp_id", 32'(rsp_id), 32'(r));
    rsp_ready = oneHot;
    step();
    rsp_ready = '0;
    step();
  endtask

  initial begin
    int order[$];
    int when[$];
    logic [31:0] holdData;

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_op    = '0;
    modelReset();
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_alu_in1", alu_in1, 32'h0);
    chk("rst_alu_in2", alu_in2, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_branch", 32'(rsp_branch), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD with operand change after acceptance, then signed/unsigned compares.
    runOne(0, 32'h0000_0010, 32'h0000_0004, OpAdd, 32'h0000_0014, 1'b0);
    runOne(1, 32'hFFFF_FFFF, 32'h0000_0001, OpBlt, 32'h0, 1'b1);
    runOne(1, 32'hFFFF_FFFF, 32'h0000_0001, OpBltu, 32'h0, 1'b0);

    // Round-robin with all requesters active and responses always accepted.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    randomizeOperands();
    req_valid = '1;
    rsp_ready = '1;
    for (int s = 0; s < 18; s++) begin
      step();
      if (lastReady != '0) begin
        int gi;
        gi = 0;
        for (int b = 0; b < NREQ; b++) if (lastReady[b]) gi = b;
        order.push_back(gi);
        when.push_back(s);
      end
    end
    chk("rr_grant_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) begin
      chk("rr_order", 32'(order[i]), 32'(i % NREQ));
      if (i > 0) chk("rr_spacing", 32'(when[i] - when[i-1]), 32'd3);
    end

    // Backpressure on requester 2 while requester 0 pulses its (ignored) rsp_ready.
    req_valid = 3'b100;
    rsp_ready = '0;
    step();
    req_valid = '1;
    step();
    #1;
    holdData = rsp_data;
    for (int c = 0; c < 5; c++) begin
      rsp_ready = (c % 2 == 0) ? 3'b001 : 3'b000;
      step();
    end
    #1;
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("bp_data_hold", rsp_data, holdData);
    chk("bp_id_hold", 32'(rsp_id), 32'd2);
    chk("bp_no_grant", 32'(req_ready), 32'h0);
    rsp_ready = 3'b100;
    step();
    rsp_ready = '0;
    step();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) randomizeOperands();
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    for (int n = 0; n < 4; n++) step();

    // Reset during ISSUE aborts the operation.
    req_valid = 3'b001;
    req_in1[31:0] = 32'h0000_1234;
    req_in2[31:0] = 32'h0000_5678;
    req_op[3:0]   = OpOr;
    rsp_ready = '0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_alu_in1", alu_in1, 32'h0);
    chk("mid_alu_in2", alu_in2, 32'h0);
    chk("mid_alu_op", 32'(alu_op), 32'h0);
    chk("mid_rsp_data", rsp_data, 32'h0);
    req_valid = 3'b110;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    rsp_ready = '1;
    for (int n = 0; n < 3; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
